// File: rtl/imem_boot_ctrl.sv
// Boot/program-load sequencer: streams instruction words into imem, pulses the
// memory reset, and holds the core in reset until the program is loaded and settled.
module imem_boot_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          RST_HOLD    = 4,
    parameter int          CLR_CYC     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic [31:0] Inst_addr_load,
    output logic [31:0] Inst_load,
    output logic        load_en,
    output logic        rst_n_mem,
    output logic        core_rst_n,
    output logic        running,
    output logic        err_ovf,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, HOLD, RUN, ERR} state_t;

    localparam logic [15:0] LAST_IDX  = 16'(DEPTH_WORDS - 1);
    localparam logic [31:0] CLR_LAST  = 32'(CLR_CYC - 1);
    localparam logic [31:0] HOLD_LAST = 32'(RST_HOLD - 1);

    state_t      state;
    logic [15:0] idx;
    logic [31:0] cnt;
    logic        accept;

    // Byte address of word i; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [15:0] i);
        return BASE_ADDR + {14'b0, i, 2'b00};
    endfunction

    assign s_ready = (state == LOAD);
    assign accept  = s_valid && s_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            cnt            <= '0;
            load_en        <= 1'b0;
            Inst_addr_load <= '0;
            Inst_load      <= '0;
            rst_n_mem      <= 1'b1;
            core_rst_n     <= 1'b0;
            running        <= 1'b0;
            err_ovf        <= 1'b0;
            words_loaded   <= '0;
        end else begin
            load_en <= 1'b0;
            case (state)
                IDLE: begin
                    core_rst_n <= 1'b0;
                    running    <= 1'b0;
                    if (start) begin
                        state        <= CLEAR;
                        rst_n_mem    <= 1'b0;
                        cnt          <= '0;
                        idx          <= '0;
                        words_loaded <= '0;
                        err_ovf      <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (cnt == CLR_LAST) begin
                        rst_n_mem <= 1'b1;
                        state     <= LOAD;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        load_en        <= 1'b1;
                        Inst_addr_load <= word_addr(idx);
                        Inst_load      <= s_data;
                        idx            <= idx + 16'd1;
                        words_loaded   <= idx + 16'd1;
                        // s_last wins over a full memory on the same word
                        if (s_last) begin
                            state <= HOLD;
                            cnt   <= '0;
                        end else if (idx == LAST_IDX) begin
                            state   <= ERR;
                            err_ovf <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        core_rst_n <= 1'b1;
                        running    <= 1'b1;
                        state      <= RUN;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                RUN: begin
                    if (halt) begin
                        core_rst_n <= 1'b0;
                        running    <= 1'b0;
                        state      <= IDLE;
                    end
                end
                ERR: begin
                    core_rst_n <= 1'b0;
                    running    <= 1'b0;
                    err_ovf    <= 1'b1;
                    if (start) begin
                        state        <= CLEAR;
                        rst_n_mem    <= 1'b0;
                        cnt          <= '0;
                        idx          <= '0;
                        words_loaded <= '0;
                        err_ovf      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: reset, nominal load, backpressure,
// overflow, halt/reload and asynchronous reset in the middle of a load.
module tb_imem_boot_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, halt, s_valid, s_last;
    logic [31:0] s_data;
    logic        s_ready, load_en, rst_n_mem, core_rst_n, running, err_ovf;
    logic [31:0] Inst_addr_load, Inst_load;
    logic [15:0] words_loaded;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] pul_addr[$];
    logic [31:0] pul_data[$];
    int          mem_low_cyc;

    always #5 clk = ~clk;

    imem_boot_ctrl #(
        .BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(4), .RST_HOLD(4), .CLR_CYC(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .Inst_addr_load(Inst_addr_load), .Inst_load(Inst_load), .load_en(load_en),
        .rst_n_mem(rst_n_mem), .core_rst_n(core_rst_n), .running(running),
        .err_ovf(err_ovf), .words_loaded(words_loaded)
    );

    // Record every write pulse and every cycle the memory reset is low
    always @(negedge clk) begin
        if (load_en) begin
            pul_addr.push_back(Inst_addr_load);
            pul_data.push_back(Inst_load);
        end
        if (!rst_n_mem) mem_low_cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one word, wait (bounded) for ready, complete the handshake edge
    task automatic send_word(input logic [31:0] d, input logic last, input int gap);
        int t;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        t = 0;
        while (!s_ready && t < 50) begin
            tick();
            t++;
        end
        if (!s_ready) chk("ready_timeout", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!s_ready && t < 50) begin
            tick();
            t++;
        end
        chk("wait_ready", 32'(s_ready), 32'd1);
    endtask

    task automatic check_pulses(input string tag, input int n);
        chk({tag, "_npulse"}, 32'(pul_addr.size()), 32'(n));
        for (int i = 0; i < n && i < pul_addr.size(); i++)
            chk({tag, "_addr"}, pul_addr[i], 32'(4 * i));
    endtask

    task automatic check_release(input string tag);
        repeat (3) tick();
        chk({tag, "_core_held"}, 32'(core_rst_n), 32'd0);
        tick();
        chk({tag, "_core_rel"}, 32'(core_rst_n), 32'd1);
        chk({tag, "_running"}, 32'(running), 32'd1);
    endtask

    logic [31:0] prog[3];

    initial begin
        prog[0] = 32'h0050_0093;
        prog[1] = 32'h00A0_0113;
        prog[2] = 32'h0020_81B3;
        rst = 1'b1; start = 1'b0; halt = 1'b0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        mem_low_cyc = 0;

        // Reset
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_load_en", 32'(load_en), 32'd0);
        chk("rst_addr", Inst_addr_load, 32'd0);
        chk("rst_data", Inst_load, 32'd0);
        chk("rst_mem", 32'(rst_n_mem), 32'd1);
        chk("rst_core", 32'(core_rst_n), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_err", 32'(err_ovf), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_nopulse", 32'(pul_addr.size()), 32'd0);

        // Nominal back-to-back load
        mem_low_cyc = 0;
        do_start();
        chk("nom_mem_low1", 32'(rst_n_mem), 32'd0);
        chk("nom_ready_clr", 32'(s_ready), 32'd0);
        tick();
        chk("nom_mem_low2", 32'(rst_n_mem), 32'd0);
        tick();
        chk("nom_mem_high", 32'(rst_n_mem), 32'd1);
        chk("nom_ready", 32'(s_ready), 32'd1);
        chk("nom_mem_cycles", 32'(mem_low_cyc), 32'd2);
        send_word(prog[0], 1'b0, 0);
        send_word(prog[1], 1'b0, 0);
        send_word(prog[2], 1'b1, 0);
        chk("nom_last_en", 32'(load_en), 32'd1);
        chk("nom_words", 32'(words_loaded), 32'd3);
        chk("nom_ready_off", 32'(s_ready), 32'd0);
        check_release("nom");
        check_pulses("nom", 3);
        for (int i = 0; i < 3 && i < pul_data.size(); i++)
            chk("nom_data", pul_data[i], prog[i]);

        // Halt
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_core", 32'(core_rst_n), 32'd0);
        chk("halt_running", 32'(running), 32'd0);

        // Backpressure: two idle cycles between words
        pul_addr.delete(); pul_data.delete();
        do_start();
        wait_ready();
        send_word(prog[0], 1'b0, 2);
        send_word(prog[1], 1'b0, 2);
        send_word(prog[2], 1'b1, 0);
        check_release("bp");
        check_pulses("bp", 3);
        for (int i = 0; i < 3 && i < pul_data.size(); i++)
            chk("bp_data", pul_data[i], prog[i]);

        // Overflow: DEPTH_WORDS=4, five words without s_last
        halt = 1'b1; tick(); halt = 1'b0;
        pul_addr.delete(); pul_data.delete();
        do_start();
        wait_ready();
        for (int i = 0; i < 4; i++) send_word(32'hA000_0000 + 32'(i), 1'b0, 0);
        chk("ovf_err", 32'(err_ovf), 32'd1);
        chk("ovf_words", 32'(words_loaded), 32'd4);
        s_valid = 1'b1; s_data = 32'hA000_0004;
        repeat (4) tick();
        chk("ovf_ready", 32'(s_ready), 32'd0);
        chk("ovf_core", 32'(core_rst_n), 32'd0);
        chk("ovf_err_hold", 32'(err_ovf), 32'd1);
        s_valid = 1'b0;
        check_pulses("ovf", 4);
        do_start();
        chk("ovf_err_clr", 32'(err_ovf), 32'd0);
        wait_ready();

        // Async reset between the 2nd and 3rd word
        pul_addr.delete(); pul_data.delete();
        send_word(prog[0], 1'b0, 0);
        send_word(prog[1], 1'b0, 0);
        s_valid = 1'b1; s_data = prog[2]; s_last = 1'b1;
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("arst_ready", 32'(s_ready), 32'd0);
        chk("arst_load_en", 32'(load_en), 32'd0);
        chk("arst_addr", Inst_addr_load, 32'd0);
        chk("arst_words", 32'(words_loaded), 32'd0);
        chk("arst_mem", 32'(rst_n_mem), 32'd1);
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        s_valid = 1'b0; s_last = 1'b0;
        chk("arst_idle_ready", 32'(s_ready), 32'd0);
        check_pulses("arst", 2);

        // Reload after halt: a single word program
        do_start();
        wait_ready();
        pul_addr.delete(); pul_data.delete();
        send_word(32'h0000_0013, 1'b1, 0);
        chk("rl_words", 32'(words_loaded), 32'd1);
        check_release("rl");
        check_pulses("rl", 1);
        halt = 1'b1; tick(); halt = 1'b0;
        chk("rl_halt_core", 32'(core_rst_n), 32'd0);
        pul_addr.delete(); pul_data.delete();
        do_start();
        wait_ready();
        send_word(32'h0000_0073, 1'b1, 0);
        chk("rl2_words", 32'(words_loaded), 32'd1);
        check_release("rl2");
        check_pulses("rl2", 1);
        if (pul_data.size() > 0) chk("rl2_data", pul_data[0], 32'h0000_0073);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
